// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: 2-flop RXD synchronizer, deframing FSM and a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 frames (extra even-parity bit between data and stop).
module uart_rx_frontend #(
  parameter int CLK_FREQ_HZ = 10000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       BUSY
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t        state, state_n;
  logic          rx_meta, rxs;
  logic [CW-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          byte_done, ferr_n;
`ifdef UART_RX_PARITY_EN
  logic          par_err, par_err_n;
`endif

  // RXD is asynchronous; the synchronizer resets to the idle level
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
`ifdef UART_RX_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
`ifdef UART_RX_PARITY_EN
      par_err <= par_err_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    byte_done = 1'b0;
    ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_n = par_err;
`endif
    case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_n   = S_START;
          clk_cnt_n = '0;
        end
      end
      S_START: begin
        // a start bit that is already high at mid-bit is treated as a glitch
        if (clk_cnt == HALF_CNT) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          state_n   = rxs ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_n = '0;
          shift_n   = {rxs, shift[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == 3'd7) state_n = S_PARITY;
`else
          if (bit_cnt == 3'd7) state_n = S_STOP;
`endif
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_n = '0;
          par_err_n = ^{shift, rxs};
          state_n   = S_STOP;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (clk_cnt == LAST_CNT) begin
          clk_cnt_n = '0;
          if (!rxs) begin
            ferr_n  = 1'b1;
            state_n = S_WAIT_HIGH;
          end else begin
            state_n = S_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_err) ferr_n = 1'b1;
            else         byte_done = 1'b1;
`else
            byte_done = 1'b1;
`endif
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        // hold here through a break so it never decodes as bytes
        if (rxs) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // holding register: a new byte may replace one being accepted on the same edge
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      RX_DATA   <= '0;
      RX_VALID  <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      FRAME_ERR <= ferr_n;
      OVERRUN   <= 1'b0;
      if (byte_done) begin
        if (!RX_VALID || RX_READY) begin
          RX_DATA  <= shift;
          RX_VALID <= 1'b1;
        end else begin
          OVERRUN  <= 1'b1;
        end
      end else if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end
    end
  end

  assign BUSY = (state != S_IDLE);

endmodule
